// File: rtl/complex_axpy_pkg.sv
// Shared constants, FSM state type and sizing helper for the complex AXPY sequencer.
package complex_axpy_pkg;

    localparam int unsigned ELEMENT_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/axpy_valid_delay.sv
// Fixed-depth shift register carrying {valid, chunk address, last flag} alongside the
// datapath pipeline; a synchronous reset flushes every stage.
module axpy_valid_delay #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  last_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  empty_next_o
);

    logic [DEPTH-1:0]      valid_d, valid_q;
    logic [DEPTH-1:0]      last_d, last_q;
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    // Address and last are zeroed on idle slots so the outputs read as zero when not valid.
    always_comb begin
        valid_d[0] = valid_i;
        last_d[0]  = valid_i & last_i;
        addr_d[0]  = valid_i ? addr_i : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            last_d[i]  = last_q[i-1];
            addr_d[i]  = addr_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];
    assign last_o  = last_q[DEPTH-1];

    // True when nothing other than the current output slot is still in flight.
    always_comb begin
        logic pending;
        pending = valid_i;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            pending = pending | valid_q[i];
        end
        empty_next_o = ~pending;
    end

endmodule

// File: rtl/complex_axpy_sequencer.sv
// Chunked read/issue/write-back sequencer for the NI-lane complex multiply-add datapath.
// Optional cycle counter port perf_cycles is enabled by COMPLEX_AXPY_PERF_COUNT_EN.
module complex_axpy_sequencer #(
    parameter int unsigned NOE           = 19,
    parameter int unsigned NI            = 8,
    parameter int unsigned ELEMENT_WIDTH = complex_axpy_pkg::ELEMENT_WIDTH,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned PIPE_LATENCY  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        op_in,
    input  logic [ELEMENT_WIDTH-1:0]    constant_in,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [ELEMENT_WIDTH*NI-1:0] rd_x_data,
    input  logic [ELEMENT_WIDTH*NI-1:0] rd_y_data,
    output logic                        dp_valid,
    output logic [ELEMENT_WIDTH*NI-1:0] dp_x,
    output logic [ELEMENT_WIDTH*NI-1:0] dp_y,
    output logic [ELEMENT_WIDTH-1:0]    dp_constant,
    output logic                        dp_op,
    input  logic [ELEMENT_WIDTH*NI-1:0] dp_result,
    output logic                        wr_en,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [ELEMENT_WIDTH*NI-1:0] wr_data,
    output logic [NI-1:0]               wr_mask
`ifdef COMPLEX_AXPY_PERF_COUNT_EN
    ,
    output logic [31:0]                 perf_cycles
`endif
);

    import complex_axpy_pkg::*;

    localparam int unsigned NCH        = ceil_div(NOE, NI);
    localparam int unsigned VALID_LAST = NOE - (NCH - 1) * NI;
    localparam logic [NI-1:0] FULL_MASK = '1;
    localparam logic [NI-1:0] LAST_MASK = ~(FULL_MASK >> VALID_LAST);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NCH - 1);

    state_e                    state_d, state_q;
    logic [ADDR_WIDTH-1:0]     chunk_d, chunk_q;
    logic [ELEMENT_WIDTH-1:0]  const_d, const_q;
    logic                      op_d, op_q;
    logic                      issue_valid_d, issue_valid_q;
    logic [ADDR_WIDTH-1:0]     issue_addr_d, issue_addr_q;
    logic                      issue_last_d, issue_last_q;

    logic                      line_valid;
    logic [ADDR_WIDTH-1:0]     line_addr;
    logic                      line_last;
    logic                      line_empty_next;

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        const_d = const_q;
        op_d    = op_q;
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    chunk_d = '0;
                    const_d = constant_in;
                    op_d    = op_in;
                end
            end
            StIssue: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                chunk_d = chunk_q + 1'b1;
                if (chunk_q == LAST_ADDR) begin
                    state_d = StDrain;
                    chunk_d = '0;
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (line_empty_next) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_addr = chunk_q;

    // Read data arrives one cycle after rd_en, so the issue stage follows the read stage.
    always_comb begin
        issue_valid_d = rd_en;
        issue_addr_d  = rd_en ? chunk_q : '0;
        issue_last_d  = rd_en && (chunk_q == LAST_ADDR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            chunk_q       <= '0;
            const_q       <= '0;
            op_q          <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_addr_q  <= '0;
            issue_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            chunk_q       <= chunk_d;
            const_q       <= const_d;
            op_q          <= op_d;
            issue_valid_q <= issue_valid_d;
            issue_addr_q  <= issue_addr_d;
            issue_last_q  <= issue_last_d;
        end
    end

    // Padding lanes of the last chunk go to the datapath as zero.
    always_comb begin
        dp_x = '0;
        dp_y = '0;
        if (issue_valid_q) begin
            for (int unsigned j = 0; j < NI; j++) begin
                if (!issue_last_q || LAST_MASK[NI-1-j]) begin
                    dp_x[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] =
                        rd_x_data[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
                    dp_y[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] =
                        rd_y_data[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
                end
            end
        end
    end

    assign dp_valid    = issue_valid_q;
    assign dp_constant = const_q;
    assign dp_op       = op_q;

    axpy_valid_delay #(
        .DEPTH      (PIPE_LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_valid_delay (
        .clk_i        (clk),
        .reset_i      (reset),
        .valid_i      (issue_valid_q),
        .addr_i       (issue_addr_q),
        .last_i       (issue_last_q),
        .valid_o      (line_valid),
        .addr_o       (line_addr),
        .last_o       (line_last),
        .empty_next_o (line_empty_next)
    );

    always_comb begin
        wr_en   = line_valid;
        wr_addr = line_addr;
        wr_data = dp_result;
        wr_mask = '0;
        if (line_valid) begin
            wr_mask = line_last ? LAST_MASK : FULL_MASK;
        end
    end

`ifdef COMPLEX_AXPY_PERF_COUNT_EN
    logic [31:0] perf_d, perf_q;

    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle && start) begin
            perf_d = '0;
        end else if (busy) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_complex_axpy_sequencer.sv
// Directed bench for complex_axpy_sequencer: default NOE=19 instance plus an NOE=16 instance.
module tb_complex_axpy_sequencer;

    localparam int EW = 64;
    localparam int NI = 8;
    localparam int AW = 8;
    localparam int L  = 8;
    localparam int DW = EW * NI;
    localparam int XB = 'h100;
    localparam int YB = 'h4000;
    localparam logic [EW-1:0] C_ONE = 64'h3f800000_00000000;
    localparam logic [EW-1:0] C_TWO = 64'h40000000_3f800000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          start_a, op_a, busy_a, done_a, rd_en_a, dp_valid_a, dp_op_a, wr_en_a;
    logic [EW-1:0] c_a, dp_c_a;
    logic [AW-1:0] rd_addr_a, wr_addr_a;
    logic [DW-1:0] rd_x_a, rd_y_a, dp_x_a, dp_y_a, dp_res_a, wr_data_a;
    logic [NI-1:0] wr_mask_a;

    logic          start_b, op_b, busy_b, done_b, rd_en_b, dp_valid_b, dp_op_b, wr_en_b;
    logic [EW-1:0] c_b, dp_c_b;
    logic [AW-1:0] rd_addr_b, wr_addr_b;
    logic [DW-1:0] rd_x_b, rd_y_b, dp_x_b, dp_y_b, dp_res_b, wr_data_b;
    logic [NI-1:0] wr_mask_b;

`ifdef COMPLEX_AXPY_PERF_COUNT_EN
    logic [31:0] perf_a, perf_b;
`endif

    complex_axpy_sequencer u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start_a),
        .op_in       (op_a),
        .constant_in (c_a),
        .busy        (busy_a),
        .done        (done_a),
        .rd_en       (rd_en_a),
        .rd_addr     (rd_addr_a),
        .rd_x_data   (rd_x_a),
        .rd_y_data   (rd_y_a),
        .dp_valid    (dp_valid_a),
        .dp_x        (dp_x_a),
        .dp_y        (dp_y_a),
        .dp_constant (dp_c_a),
        .dp_op       (dp_op_a),
        .dp_result   (dp_res_a),
        .wr_en       (wr_en_a),
        .wr_addr     (wr_addr_a),
        .wr_data     (wr_data_a),
        .wr_mask     (wr_mask_a)
`ifdef COMPLEX_AXPY_PERF_COUNT_EN
        ,
        .perf_cycles (perf_a)
`endif
    );

    complex_axpy_sequencer #(
        .NOE (16)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .op_in       (op_b),
        .constant_in (c_b),
        .busy        (busy_b),
        .done        (done_b),
        .rd_en       (rd_en_b),
        .rd_addr     (rd_addr_b),
        .rd_x_data   (rd_x_b),
        .rd_y_data   (rd_y_b),
        .dp_valid    (dp_valid_b),
        .dp_x        (dp_x_b),
        .dp_y        (dp_y_b),
        .dp_constant (dp_c_b),
        .dp_op       (dp_op_b),
        .dp_result   (dp_res_b),
        .wr_en       (wr_en_b),
        .wr_addr     (wr_addr_b),
        .wr_data     (wr_data_b),
        .wr_mask     (wr_mask_b)
`ifdef COMPLEX_AXPY_PERF_COUNT_EN
        ,
        .perf_cycles (perf_b)
`endif
    );

    // Lane j of chunk a; lanes at or beyond nvalid are zero.
    function automatic logic [DW-1:0] chunk(input int a, input int base, input int nvalid);
        logic [DW-1:0] v;
        v = '0;
        for (int j = 0; j < NI; j++) begin
            if (j < nvalid) begin
                v[EW*(NI-j)-1 -: EW] = {32'(base + a*NI + j), 32'(base + 'h80 + a*NI + j)};
            end
        end
        return v;
    endfunction

    // Memories return full chunks, including lanes past the vector end.
    always @(posedge clk) begin
        rd_x_a <= rd_en_a ? chunk(int'(rd_addr_a), XB, NI) : '0;
        rd_y_a <= rd_en_a ? chunk(int'(rd_addr_a), YB, NI) : '0;
        rd_x_b <= rd_en_b ? chunk(int'(rd_addr_b), XB, NI) : '0;
        rd_y_b <= rd_en_b ? chunk(int'(rd_addr_b), YB, NI) : '0;
    end

    // Datapath stand-in: dp_x delayed by the pipeline latency.
    logic [DW-1:0] pipe_a [L];
    always @(posedge clk) begin
        pipe_a[0] <= dp_x_a;
        for (int i = 1; i < L; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign dp_res_a = pipe_a[L-1];
    assign dp_res_b = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Default instance run; returns in cycle k+14 with start low.
    task automatic run_a(input logic [EW-1:0] c, input logic op, input bit inject);
        c_a     = c;
        op_a    = op;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        c_a     = ~c;
        op_a    = ~op;
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) tick();
            chk($sformatf("a.rd_en@%0d", n), rd_en_a, n >= 1 && n <= 3);
            if (n <= 3) chk($sformatf("a.rd_addr@%0d", n), rd_addr_a, n - 1);
            chk($sformatf("a.dp_valid@%0d", n), dp_valid_a, n >= 2 && n <= 4);
            if (n >= 2 && n <= 4) begin
                chk($sformatf("a.dp_x@%0d", n), dp_x_a, chunk(n - 2, XB, (n == 4) ? 3 : NI));
                chk($sformatf("a.dp_y@%0d", n), dp_y_a, chunk(n - 2, YB, (n == 4) ? 3 : NI));
            end
            chk($sformatf("a.wr_en@%0d", n), wr_en_a, n >= 10 && n <= 12);
            if (n >= 10 && n <= 12) begin
                chk($sformatf("a.wr_addr@%0d", n), wr_addr_a, n - 10);
                chk($sformatf("a.wr_mask@%0d", n), wr_mask_a, (n == 12) ? 8'hE0 : 8'hFF);
                chk($sformatf("a.wr_data@%0d", n), wr_data_a,
                    chunk(n - 10, XB, (n == 12) ? 3 : NI));
            end
            chk($sformatf("a.done@%0d", n), done_a, n == 13);
            chk($sformatf("a.busy@%0d", n), busy_a, n >= 1 && n <= 12);
            chk($sformatf("a.dp_constant@%0d", n), dp_c_a, c);
            chk($sformatf("a.dp_op@%0d", n), dp_op_a, op);
            start_a = inject && (n == 5 || n == 13);
        end
`ifdef COMPLEX_AXPY_PERF_COUNT_EN
        chk("a.perf_cycles", perf_a, 32'd12);
`endif
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        op_a    = 1'b0;
        op_b    = 1'b0;
        c_a     = '0;
        c_b     = '0;
        repeat (3) tick();

        chk("rst.busy", busy_a, 1'b0);
        chk("rst.done", done_a, 1'b0);
        chk("rst.rd_en", rd_en_a, 1'b0);
        chk("rst.rd_addr", rd_addr_a, '0);
        chk("rst.dp_valid", dp_valid_a, 1'b0);
        chk("rst.dp_x", dp_x_a, '0);
        chk("rst.dp_y", dp_y_a, '0);
        chk("rst.dp_constant", dp_c_a, '0);
        chk("rst.dp_op", dp_op_a, 1'b0);
        chk("rst.wr_en", wr_en_a, 1'b0);
        chk("rst.wr_addr", wr_addr_a, '0);
        chk("rst.wr_mask", wr_mask_a, '0);
        chk("rst.b.wr_mask", wr_mask_b, '0);
`ifdef COMPLEX_AXPY_PERF_COUNT_EN
        chk("rst.perf", perf_a, 32'd0);
`endif
        reset = 1'b0;
        tick();

        run_a(C_ONE, 1'b0, 1'b0);
        tick();
        // Ignored starts at k+5 and k+13, then a fresh run launched at k+14.
        run_a(C_ONE, 1'b1, 1'b1);
        run_a(C_TWO, 1'b0, 1'b0);

        // Reset in the middle of a run.
        c_a     = C_TWO;
        op_a    = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            chk($sformatf("flush.wr_en@%0d", n), wr_en_a, 1'b0);
            chk($sformatf("flush.done@%0d", n), done_a, 1'b0);
            chk($sformatf("flush.busy@%0d", n), busy_a, 1'b0);
            chk($sformatf("flush.rd_en@%0d", n), rd_en_a, 1'b0);
            chk($sformatf("flush.dp_valid@%0d", n), dp_valid_a, 1'b0);
            chk($sformatf("flush.dp_x@%0d", n), dp_x_a, '0);
            chk($sformatf("flush.wr_mask@%0d", n), wr_mask_a, '0);
            chk($sformatf("flush.wr_addr@%0d", n), wr_addr_a, '0);
            chk($sformatf("flush.dp_constant@%0d", n), dp_c_a, '0);
            chk($sformatf("flush.dp_op@%0d", n), dp_op_a, 1'b0);
            tick();
        end
        run_a(C_ONE, 1'b0, 1'b0);

        // NOE=16 instance: two full chunks, done at k+12.
        c_b     = C_TWO;
        op_b    = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            if (n > 1) tick();
            chk($sformatf("b.rd_en@%0d", n), rd_en_b, n >= 1 && n <= 2);
            chk($sformatf("b.dp_valid@%0d", n), dp_valid_b, n >= 2 && n <= 3);
            if (n == 3) chk("b.dp_x_last", dp_x_b, chunk(1, XB, NI));
            chk($sformatf("b.wr_en@%0d", n), wr_en_b, n >= 10 && n <= 11);
            if (n >= 10 && n <= 11) begin
                chk($sformatf("b.wr_addr@%0d", n), wr_addr_b, n - 10);
                chk($sformatf("b.wr_mask@%0d", n), wr_mask_b, 8'hFF);
            end
            chk($sformatf("b.done@%0d", n), done_b, n == 12);
            chk($sformatf("b.busy@%0d", n), busy_b, n >= 1 && n <= 11);
            chk($sformatf("b.dp_op@%0d", n), dp_op_b, 1'b1);
        end
`ifdef COMPLEX_AXPY_PERF_COUNT_EN
        chk("b.perf_cycles", perf_b, 32'd11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
